// File: rtl/Noc_parameters.sv
// Shared NoC types: flit layout, flit kinds, router state and output port indices.
package Noc_parameters;

    localparam int unsigned Noc_VC_Channel = 2;
    localparam int unsigned COORD_W        = 4;
    localparam int unsigned PAYLOAD_W      = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e           ftype;
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam int unsigned FLIT_W = $bits(flit_t);

    // One-hot output port positions on the route select
    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_NORTH = 1;
    localparam int unsigned PORT_EAST  = 2;
    localparam int unsigned PORT_SOUTH = 3;
    localparam int unsigned PORT_WEST  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } route_state_e;

endpackage

// File: rtl/Noc_flit_interface.sv
// Flit link: valid/ready handshake forward, per-VC credit readiness backward.
interface Noc_flit_interface
    import Noc_parameters::*;
#(
    parameter int unsigned CHANNELS = Noc_VC_Channel
);
    logic                valid;
    logic                ready;
    flit_t               flit;
    logic [CHANNELS-1:0] vc_ready;

    modport sender   (output valid, output flit, input  ready, input  vc_ready);
    modport receiver (input  valid, input  flit, output ready, output vc_ready);
endinterface

// File: rtl/noc_flit_fifo.sv
// Input flit FIFO with registered occupancy count and wrapping pointers.
module noc_flit_fifo
    import Noc_parameters::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  flit_t                    in_flit_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output flit_t                    out_flit_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             en_q;
    logic             push, pop;

    // Ready comes only from registered state; en_q holds it low until the first edge out of reset
    assign in_ready_o  = en_q && (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign out_flit_o  = mem[rd_ptr_q];
    assign count_o     = count_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Next pointers and count; simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and enable registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= 1'b1;
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= in_flit_i;
        end
    end

endmodule

// File: rtl/noc_route_compute.sv
// Router input stage: buffers flits, XY-routes each packet head, forwards the packet, drops stray body flits.
module noc_route_compute
    import Noc_parameters::*;
#(
    parameter int unsigned CHANNELS = Noc_VC_Channel,
    parameter int unsigned ENTRIES  = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned X_ID     = 0,
    parameter int unsigned Y_ID     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    Noc_flit_interface.receiver  receiver_if,
    Noc_flit_interface.sender    sender_if,
    output logic [ENTRIES-1:0]   o_select,
    output logic                 o_err
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

    route_state_e       state_q, state_d;
    logic [ENTRIES-1:0] select_q, select_d;
    logic               err_q, err_d;
    logic [ENTRIES-1:0] route_sel;

    flit_t              head;
    logic               fifo_out_valid;
    logic               fifo_out_ready;
    logic [CNT_W-1:0]   fifo_count;
    logic               is_head, is_last;
    logic               send_valid, transfer, drop;

    noc_flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .in_valid_i  (receiver_if.valid),
        .in_ready_o  (receiver_if.ready),
        .in_flit_i   (receiver_if.flit),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (fifo_out_ready),
        .out_flit_o  (head),
        .count_o     (fifo_count)
    );

    assign receiver_if.vc_ready = sender_if.vc_ready[CHANNELS-1:0];
    assign sender_if.valid      = send_valid;
    assign sender_if.flit       = head;
    assign o_select             = select_q;
    assign o_err                = err_q;

    assign is_head = (head.ftype == HEAD) || (head.ftype == HEADTAIL);
    assign is_last = (head.ftype == TAIL) || (head.ftype == HEADTAIL);

    // Dimension-ordered route of the head flit: resolve X first, then Y
    always_comb begin
        route_sel = '0;
        if (head.dest_x > MY_X) begin
            route_sel[PORT_EAST] = 1'b1;
        end else if (head.dest_x < MY_X) begin
            route_sel[PORT_WEST] = 1'b1;
        end else if (head.dest_y > MY_Y) begin
            route_sel[PORT_NORTH] = 1'b1;
        end else if (head.dest_y < MY_Y) begin
            route_sel[PORT_SOUTH] = 1'b1;
        end else begin
            route_sel[PORT_LOCAL] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a head opens a packet, the last flit leaving closes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_out_valid && is_head) state_d = ACTIVE;
            ACTIVE:  if (transfer && is_last)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: forwarding handshake, stray-flit drop and route select hold
    always_comb begin
        send_valid     = (state_q == ACTIVE) && (fifo_count != '0);
        transfer       = send_valid && sender_if.ready;
        drop           = (state_q == IDLE) && fifo_out_valid && !is_head;
        fifo_out_ready = (state_q == ACTIVE) ? sender_if.ready : drop;
        err_d          = drop;
        select_d       = '0;
        if ((state_q == IDLE) && fifo_out_valid && is_head) begin
            select_d = route_sel;
        end else if ((state_q == ACTIVE) && !(transfer && is_last)) begin
            select_d = select_q;
        end
    end

    // Registered route select and error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            select_q <= '0;
            err_q    <= 1'b0;
        end else begin
            select_q <= select_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/noc_route_compute.md
NOC_ROUTE_COMPUTE -- requirements
Module: noc_route_compute

Interface
REQ-001 SHALL have parameter CHANNELS, default Noc_VC_Channel: number of virtual channels carried on vc_ready.
REQ-002 SHALL have parameter ENTRIES, default 5: output ports, one-hot order bit0 Local, bit1 North, bit2 East, bit3 South, bit4 West.
REQ-003 SHALL have parameter DEPTH, default 4: input FIFO depth in flits, a power of two and at least 2.
REQ-004 SHALL have parameters X_ID and Y_ID, default 0: router mesh coordinates.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port receiver_if, Noc_flit_interface.receiver: upstream flit stream.
REQ-008 SHALL have port sender_if, Noc_flit_interface.sender: flit stream towards the output demux.
REQ-009 SHALL have port o_select, output, ENTRIES bits: one-hot route select for the demux.
REQ-010 SHALL have port o_err, output, 1 bit: one-cycle pulse when a flit is dropped.

Function
REQ-011 SHALL buffer input flits in a DEPTH-entry FIFO; receiver_if.ready = FIFO not full, taken from a registered count with no same-cycle bypass.
REQ-012 SHALL accept a push when receiver_if.valid && receiver_if.ready are both high.
REQ-013 SHALL drive receiver_if.vc_ready = sender_if.vc_ready combinationally, CHANNELS bits wide.
REQ-014 SHALL run a two-state FSM, IDLE and ACTIVE; o_select = 0 in IDLE.
REQ-015 SHALL, in IDLE, when the FIFO head is HEAD or HEADTAIL, compute the XY route and register it into o_select, entering ACTIVE next cycle (1-cycle route latency).
REQ-016 SHALL route by X first: dest_x > X_ID -> East; dest_x < X_ID -> West; else dest_y > Y_ID -> North; dest_y < Y_ID -> South; else Local.
REQ-017 SHALL, in IDLE, pop a BODY or TAIL flit found at the FIFO head without forwarding it and pulse o_err for one cycle.
REQ-018 SHALL drive sender_if.valid = ACTIVE && FIFO not empty, and sender_if.flit = FIFO head.
REQ-019 SHALL pop the FIFO when sender_if.valid && sender_if.ready are both high.
REQ-020 SHALL hold o_select constant throughout ACTIVE.
REQ-021 SHALL return to IDLE on the cycle after a TAIL or HEADTAIL flit transfers out; the next head is routed no earlier than the following cycle.
REQ-022 SHALL support push and pop in the same cycle, leaving count unchanged.
REQ-023 SHALL use FIFO pointers of log2(DEPTH) bits that wrap modulo DEPTH, with a count of log2(DEPTH)+1 bits.

Reset
REQ-024 SHALL, while i_rst_n = 0, set: FSM = IDLE; pointers and count = 0; o_select = 0; o_err = 0; sender_if.valid = 0; receiver_if.ready = 0.
REQ-025 SHALL discard buffered flits and any partial packet on reset mid-packet, with no o_err pulse.
REQ-026 SHALL raise receiver_if.ready on the first clock edge after reset deasserts.

Structure
REQ-027 SHALL define in Noc_parameters: flit_type_e {HEAD, BODY, TAIL, HEADTAIL}, the flit field layout (type, dest_x, dest_y), and the port index constants.
REQ-028 SHALL implement the FIFO as sub-module noc_flit_fifo with its own valid/ready and count.
REQ-029 SHALL keep route computation as combinational logic inside noc_route_compute.

Verification
REQ-030 SHALL check: X_ID=1, Y_ID=1; HEADTAIL to (3,1) -> o_select=5'b00100 one cycle later; flit out; IDLE after transfer.
REQ-031 SHALL check: HEAD to (1,0), BODY, BODY, TAIL, with sender ready stalled 3 cycles mid-packet -> o_select=5'b01000 held for all 4 flits, order preserved, IDLE after TAIL.
REQ-032 SHALL check: DEPTH=4, sender ready=0, 6 flits offered -> ready low after 4 pushes; no loss; all 6 delivered in order once ready=1.
REQ-033 SHALL check: BODY flit arrives in IDLE -> popped, o_err=1 for exactly one cycle, sender valid stays 0.
REQ-034 SHALL check: i_rst_n pulsed low mid-packet with 3 flits buffered -> count=0, o_select=0, valid=0 immediately; next HEAD to (1,1) -> o_select=5'b00001.
REQ-035 SHALL check: push and pop every cycle for 10 cycles with pointer wrap -> count constant, data intact.
